pic_interrupt_control: RTL
==========================

// Module: pic_interrupt_control
// PURPOSE
//  Control stage directly upstream of the PIC in-service register. Arbitrates masked requests against the
//  in-service level and raises int_out. Runs the 8086 two-pulse INTA sequence and drives the vector byte.
//  Generates the one-cycle set (interrupt/latch_isr) and clear (end_interrupt) pulses that the ISR consumes.
// PARAMETERS
//  SYNC_STAGES     2    flops in the inta_n synchroniser (>=2)
//  SPURIOUS_LEVEL  7    level reported in the vector when the request vanishes before ACK1
// PORTS
//  clk                       in   1  system clock
//  reset                     in   1  asynchronous, active-high reset
//  irr                       in   8  pending requests from the request register
//  imr                       in   8  mask register, 1 = masked
//  isr                       in   8  current in-service register
//  highest_level_in_service  in   8  one-hot highest in-service level (rotation-resolved)
//  inta_n                    in   1  CPU acknowledge strobe, asynchronous, active-low
//  vector_base               in   5  ICW2 T7..T3
//  eoi_cmd                   in   1  one-cycle OCW2 EOI strobe
//  eoi_specific              in   1  1 = specific EOI using eoi_level
//  eoi_level                 in   3  level for specific EOI
//  rotate_on_eoi             in   1  rotate priority on this EOI
//  auto_eoi                  in   1  ICW4 AEOI mode
//  int_out                   out  1  interrupt request to the CPU
//  interrupt                 out  8  one-hot level to set in the ISR (pulse)
//  latch_isr                 out  1  qualifies interrupt (pulse)
//  clear_irr                 out  8  one-hot edge-latch clear to the IRR (pulse)
//  end_interrupt             out  8  one-hot ISR clear (pulse)
//  priority_rotate           out  3  lowest-priority level; highest priority = (priority_rotate+1) mod 8
//  data_out                  out  8  vector byte {vector_base, level}
//  data_out_en               out  1  drive enable for data_out
// BEHAVIOUR
//  - Reset: state IDLE; priority_rotate = 3'd7. All other outputs 0. Reset mid-sequence aborts with no ISR change.
//  - inta_n passes through SYNC_STAGES flops. Falling and rising edges are detected on the synchronised copy.
//  - Arbitration (combinational, registered into int_out):
//    - req = irr & ~imr. Resolve req and isr with the same rotation.
//    - int_out = 1 next cycle when the winner is strictly higher priority than the highest in-service bit,
//      or when isr == 0.
//  - FSM IDLE -> ACK1 -> ACK2 -> IDLE:
//    - IDLE: inta falling edge -> ACK1. Freeze the winner level into ack_level.
//      - If a winner exists: pulse interrupt = latch_isr = clear_irr = onehot(ack_level) for 1 cycle.
//      - If no winner (spurious): ack_level = SPURIOUS_LEVEL and no pulses.
//      - int_out drops the same cycle.
//    - ACK1: next inta falling edge -> ACK2. data_out = {vector_base, ack_level} and data_out_en = 1
//      while synced inta is low.
//    - ACK2: inta rising edge -> IDLE. Clear data_out_en.
//  - Arbitration is frozen from ACK1 to IDLE; int_out stays 0.
//  - EOI is a 1-cycle end_interrupt pulse, issued 1 cycle after eoi_cmd:
//    - Non-specific: clears highest_level_in_service.
//    - Specific: clears onehot(eoi_level).
//    - rotate_on_eoi: priority_rotate <= cleared level. A non-specific EOI with isr == 0 clears nothing
//      and does not rotate.
//  - eoi_cmd in the same cycle as the ACK1 latch pulse: the EOI is held in a pending flop and issued the
//    following cycle, never the same cycle as latch_isr. A further eoi_cmd while one is pending is dropped.
//  - Outputs are registered; vector latency is 1 clk after the synced edge.
// CONFIGURATION
//  - PIC_AUTO_EOI_EN defined: auto_eoi = 1 pulses end_interrupt = onehot(ack_level) on the ACK2->IDLE
//    transition. Spurious acknowledges get no pulse.
//  - PIC_AUTO_EOI_EN undefined: the auto_eoi port exists but is ignored. end_interrupt comes only from eoi_cmd.
// STRUCTURE
//  - Package pic_pkg:
//    - ack state enum (IDLE, ACK1, ACK2)
//    - functions rotate_right, rotate_left, resolve_priority
//    - onehot3to8, level8to3
//  - Sub-module pic_priority_resolver: rotate, resolve, rotate back; purely combinational.
//    Instantiated twice, for req and for isr.
// TESTING
//  1. irr=8'h10, imr=0, isr=0: int_out=1.
//     Two INTA pulses, vector_base=5'h08: interrupt=8'h10 pulse at ACK1, data_out=8'h44, then IDLE.
//  2. isr=8'h04, irr=8'h08, priority_rotate=7: int_out stays 0.
//     irr=8'h02: int_out=1.
//  3. irr dropped to 0 after int_out, before first INTA: no latch_isr; data_out=
//     {vector_base,3'd7}.
//  4. isr=8'h28, non-specific EOI + rotate: end_interrupt=8'h08, priority_rotate=3.
//     Next arbitration ranks level 4 highest.
//  5. eoi_cmd coincident with ACK1 latch: latch_isr at cycle N, end_interrupt at N+1 only.
//  6. Reset asserted during ACK1: all outputs 0 immediately, priority_rotate=7.
//     PIC_AUTO_EOI_EN run: end_interrupt equals interrupt after ACK2.

Source files
------------

// File: rtl/pic_interrupt_control_pkg.sv
// Package pic_pkg: shared types and helpers for the PIC control stage.
//   ack_state_t      : INTA sequencer state (IDLE, ACK1, ACK2)
//   rotate_right/left: 8-bit barrel rotate by 0..7
//   resolve_priority : isolate the lowest set bit (bit 0 = highest priority)
//   onehot3to8 / level8to3 : level <-> one-hot conversion
package pic_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} ack_state_t;

  function automatic logic [7:0] rotate_right(logic [7:0] v, logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(logic [7:0] v, logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] resolve_priority(logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [7:0] onehot3to8(logic [2:0] l);
    return 8'd1 << l;
  endfunction

  function automatic logic [2:0] level8to3(logic [7:0] v);
    logic [2:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) if (v[i]) l = 3'(i);
    return l;
  endfunction
endpackage

// File: rtl/pic_interrupt_control_if.sv
// Interface bundling the ISR/IRR side and CPU side signals of the PIC control stage.
//   slave  : the control stage (consumes requests/INTA/EOI, produces pulses and vector)
//   master : the environment driving it
interface pic_interrupt_control_if;
  logic [7:0] irr, imr, isr, highest_level_in_service;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_cmd, eoi_specific, rotate_on_eoi, auto_eoi;
  logic [2:0] eoi_level;
  logic       int_out, latch_isr, data_out_en;
  logic [7:0] interrupt, clear_irr, end_interrupt, data_out;
  logic [2:0] priority_rotate;

  modport slave (
    input  irr, imr, isr, highest_level_in_service, inta_n, vector_base,
           eoi_cmd, eoi_specific, eoi_level, rotate_on_eoi, auto_eoi,
    output int_out, interrupt, latch_isr, clear_irr, end_interrupt,
           priority_rotate, data_out, data_out_en
  );
  modport master (
    output irr, imr, isr, highest_level_in_service, inta_n, vector_base,
           eoi_cmd, eoi_specific, eoi_level, rotate_on_eoi, auto_eoi,
    input  int_out, interrupt, latch_isr, clear_irr, end_interrupt,
           priority_rotate, data_out, data_out_en
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver.
//   vec    : request/in-service vector
//   rot    : lowest-priority level; level rot+1 is highest
//   winner : one-hot highest-priority set bit, original positions
//   rank   : winner position after rotation (0 = highest priority)
//   any    : vec has at least one bit set
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] rot,
  output logic [7:0] winner,
  output logic [2:0] rank,
  output logic       any
);
  logic [2:0] sh;
  logic [7:0] rotated, res;

  assign sh      = rot + 3'd1;       // brings the highest-priority level to bit 0
  assign rotated = rotate_right(vec, sh);
  assign res     = resolve_priority(rotated);
  assign winner  = rotate_left(res, sh);
  assign rank    = level8to3(res);
  assign any     = |vec;
endmodule

// File: rtl/pic_interrupt_control.sv
// PIC control stage: arbitration, int_out, 8086 two-pulse INTA sequencer, vector
// drive, and the one-cycle ISR set/clear pulses.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pic_interrupt_control_if.slave (requests, INTA, EOI in; pulses, vector out)
// Optional feature macro: PIC_AUTO_EOI_EN (auto EOI on ACK2->IDLE when auto_eoi = 1).
module pic_interrupt_control
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SPURIOUS_LEVEL = 7
) (
  input logic clk,
  input logic reset,
  pic_interrupt_control_if.slave bus
);
  logic [7:0] req, req_win, isr_win;
  logic [2:0] req_rank, isr_rank;
  logic       req_any, isr_any, int_req;

  assign req = bus.irr & ~bus.imr;

  pic_priority_resolver u_req (.vec(req),     .rot(bus.priority_rotate), .winner(req_win), .rank(req_rank), .any(req_any));
  pic_priority_resolver u_isr (.vec(bus.isr), .rot(bus.priority_rotate), .winner(isr_win), .rank(isr_rank), .any(isr_any));

  // isr_win is only needed for its rank
  logic [7:0] unused_isr_win;
  assign unused_isr_win = isr_win;

  assign int_req = req_any && (!isr_any || req_rank < isr_rank);

  // inta_n synchroniser; idles high so reset never fakes an edge
  logic [SYNC_STAGES-1:0] sync_q;
  logic inta_d, inta_s, fall, rise;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= '1;
      inta_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
      inta_d <= sync_q[SYNC_STAGES-1];
    end
  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_d & ~inta_s;
  assign rise   = ~inta_d & inta_s;

  ack_state_t state, state_nx;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fall) state_nx = ACK1;
      ACK1:    if (fall) state_nx = ACK2;
      ACK2:    if (rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // registered outputs and sequence context
  logic       int_q, latch_q, en_q, spur_q, pend_q, prot_q;
  logic [7:0] intr_q, clr_q, end_q, data_q, pmask_q;
  logic [2:0] pr_q, lvl_q;
  logic       int_d, latch_d, en_d, spur_d, pend_d, prot_d;
  logic [7:0] intr_d, clr_d, end_d, data_d, pmask_d, eoi_mask;
  logic [2:0] pr_d, lvl_d;
  logic       latch_go;

  assign latch_go = (state == IDLE) && fall;
  assign eoi_mask = bus.eoi_specific ? onehot3to8(bus.eoi_level)
                  : (isr_any ? bus.highest_level_in_service : 8'h00);

  always_comb begin
    int_d = 1'b0; latch_d = 1'b0; intr_d = '0; clr_d = '0; end_d = '0;
    en_d = en_q; data_d = data_q; lvl_d = lvl_q; spur_d = spur_q; pr_d = pr_q;
    pend_d = 1'b0; pmask_d = pmask_q; prot_d = prot_q;
    case (state)
      IDLE:
        if (fall) begin
          lvl_d  = int_req ? level8to3(req_win) : 3'(SPURIOUS_LEVEL);
          spur_d = !int_req;
          if (int_req) begin
            intr_d = req_win; clr_d = req_win; latch_d = 1'b1;
          end
        end else int_d = int_req;
      ACK1:
        if (fall) begin
          data_d = {bus.vector_base, lvl_q};
          en_d   = 1'b1;
        end
      ACK2:
        if (rise) begin
          data_d = '0;
          en_d   = 1'b0;
`ifdef PIC_AUTO_EOI_EN
          if (bus.auto_eoi && !spur_q) end_d = onehot3to8(lvl_q);
`endif
        end
      default: ;
    endcase
    // An EOI colliding with the latch pulse is deferred one cycle; any
    // eoi_cmd arriving while it waits is dropped.
    if (pend_q) begin
      end_d = end_d | pmask_q;
      if (prot_q && pmask_q != 8'h00) pr_d = level8to3(pmask_q);
    end else if (bus.eoi_cmd) begin
      if (latch_go) begin
        pend_d = 1'b1; pmask_d = eoi_mask; prot_d = bus.rotate_on_eoi;
      end else begin
        end_d = end_d | eoi_mask;
        if (bus.rotate_on_eoi && eoi_mask != 8'h00) pr_d = level8to3(eoi_mask);
      end
    end
  end

`ifndef PIC_AUTO_EOI_EN
  logic unused_auto_eoi;
  assign unused_auto_eoi = bus.auto_eoi;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      int_q <= 1'b0; latch_q <= 1'b0; en_q <= 1'b0; spur_q <= 1'b0;
      pend_q <= 1'b0; prot_q <= 1'b0; intr_q <= '0; clr_q <= '0; end_q <= '0;
      data_q <= '0; pmask_q <= '0; pr_q <= 3'd7; lvl_q <= '0;
    end else begin
      int_q <= int_d; latch_q <= latch_d; en_q <= en_d; spur_q <= spur_d;
      pend_q <= pend_d; prot_q <= prot_d; intr_q <= intr_d; clr_q <= clr_d;
      end_q <= end_d; data_q <= data_d; pmask_q <= pmask_d; pr_q <= pr_d; lvl_q <= lvl_d;
    end

  assign bus.int_out         = int_q;
  assign bus.interrupt       = intr_q;
  assign bus.latch_isr       = latch_q;
  assign bus.clear_irr       = clr_q;
  assign bus.end_interrupt   = end_q;
  assign bus.priority_rotate = pr_q;
  assign bus.data_out        = data_q;
  assign bus.data_out_en     = en_q;
endmodule
